// File: rtl/cpa_segmented_seq.sv
// Multi-cycle segmented carry-propagate adder: adds A+B+cin SEG_WIDTH bits per clock.
// Optional early termination on all-zero upper operand bits: define CPA_EARLY_TERMINATE_EN.
module cpa_segmented_seq #(
  parameter int WIDTH     = 2092,
  parameter int SEG_WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NUM_SEGS  = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int PAD_W     = NUM_SEGS * SEG_WIDTH;
  localparam int LAST_BITS = WIDTH - (NUM_SEGS - 1) * SEG_WIDTH;
  localparam int CNT_W     = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEGS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     seg_cnt;
  logic                 carry;
  logic [PAD_W-1:0]     a_reg, b_reg, sum_reg, sum_nxt;
  logic [SEG_WIDTH-1:0] a_seg, b_seg;
  logic [SEG_WIDTH:0]   seg_sum;
  int                   seg_base;
  logic                 accept, last_seg, et_fire, finish;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg[WIDTH-1:0];

  assign seg_base = int'(seg_cnt) * SEG_WIDTH;
  assign a_seg    = a_reg[seg_base +: SEG_WIDTH];
  assign b_seg    = b_reg[seg_base +: SEG_WIDTH];
  assign seg_sum  = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_WIDTH{1'b0}}, carry};
  assign last_seg = (seg_cnt == LAST_SEG);

`ifdef CPA_EARLY_TERMINATE_EN
  logic [PAD_W-1:0] upper_ab;
  // Nothing left to add above this segment and no carry to push into it.
  assign upper_ab = (a_reg | b_reg) >> (seg_base + SEG_WIDTH);
  assign et_fire  = (state == ADD) && !last_seg && !seg_sum[SEG_WIDTH] && (upper_ab == '0);
`else
  assign et_fire = 1'b0;
`endif

  assign finish = last_seg || et_fire;

  always_comb begin
    sum_nxt = sum_reg;
    sum_nxt[seg_base +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
    if (et_fire) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        if (i > int'(seg_cnt)) sum_nxt[i*SEG_WIDTH +: SEG_WIDTH] = '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (finish) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: held untouched for the whole ADD pass.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= PAD_W'(in_a);
      b_reg <= PAD_W'(in_b);
    end
  end

  // Control and result: one segment per clock, carry chained through a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      seg_cnt  <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      out_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        carry   <= in_cin;
        seg_cnt <= '0;
      end else if (state == ADD) begin
        sum_reg <= sum_nxt;
        carry   <= seg_sum[SEG_WIDTH];
        // In a padded last segment the true carry sits at bit LAST_BITS, not at the top.
        if (finish) out_cout <= et_fire ? 1'b0 : seg_sum[LAST_BITS];
        else        seg_cnt  <= seg_cnt + 1'b1;
      end
    end
  end

  generate
    if (PAD_W > WIDTH) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^sum_reg[PAD_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_cpa_segmented_seq.sv
// Bench for cpa_segmented_seq: a 16/4 instance and a padded 10/4 instance against an arithmetic model.
module tb_cpa_segmented_seq;

  localparam int W0 = 16, S0 = 4, W1 = 10, S1 = 4;
`ifdef CPA_EARLY_TERMINATE_EN
  localparam int LAT_T1 = 3, LAT_T6 = 1;
`else
  localparam int LAT_T1 = 4, LAT_T6 = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic v0, r0, c0, ov0, or0, co0;
  logic [W0-1:0] a0, b0, s0;
  logic v1, r1, c1, ov1, or1, co1;
  logic [W1-1:0] a1, b1, s1;

  int vectors = 0, miscompares = 0, cyc = 0, t_acc0 = 0, t_acc1 = 0;
  bit acc0_f, acc1_f;

  typedef struct { logic [63:0] sum; logic cout; int due; } exp_t;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  cpa_segmented_seq #(.WIDTH(W0), .SEG_WIDTH(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0),
    .in_cin(c0), .out_valid(ov0), .out_ready(or0), .out_sum(s0), .out_cout(co0));

  cpa_segmented_seq #(.WIDTH(W1), .SEG_WIDTH(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .in_cin(c1), .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_cout(co1));

  function automatic logic [63:0] msk(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int model_lat(logic [63:0] a, logic [63:0] b, logic cin, int w, int s);
    int n;
    n = (w + s - 1) / s;
`ifdef CPA_EARLY_TERMINATE_EN
    for (int k = 0; k < n - 1; k++) begin
      int hb;
      hb = (k + 1) * s;
      if ((((a & msk(hb)) + (b & msk(hb)) + 64'(cin)) >> hb) == 64'd0 && ((a | b) >> hb) == 64'd0)
        return k + 1;
    end
`endif
    return n;
  endfunction

  function automatic exp_t model_res(logic [63:0] a, logic [63:0] b, logic cin, int w, int s, int now);
    logic [63:0] t;
    exp_t e;
    t = a + b + 64'(cin);
    e.sum  = t & msk(w);
    e.cout = t[w];
    e.due  = now + model_lat(a, b, cin, w, s);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    bit vm0, vm1, rdy0, rdy1, hs0, hs1;
    #1;
    vm0 = (q0.size() != 0) && (q0[0].due <= cyc);
    vm1 = (q1.size() != 0) && (q1[0].due <= cyc);
    hs0 = vm0 && or0;
    hs1 = vm1 && or1;
    acc0_f = v0 && ((q0.size() == 0) || hs0) && rst_n;
    acc1_f = v1 && ((q1.size() == 0) || hs1) && rst_n;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (hs0) void'(q0.pop_front());
      if (acc0_f) q0.push_back(model_res(64'(a0), 64'(b0), c0, W0, S0, cyc));
      if (hs1) void'(q1.pop_front());
      if (acc1_f) q1.push_back(model_res(64'(a1), 64'(b1), c1, W1, S1, cyc));
    end
    @(negedge clk);
    vm0 = (q0.size() != 0) && (q0[0].due <= cyc);
    vm1 = (q1.size() != 0) && (q1[0].due <= cyc);
    rdy0 = (q0.size() == 0) || (vm0 && or0);
    rdy1 = (q1.size() == 0) || (vm1 && or1);
    chk("in_ready0", r0, rdy0);
    chk("out_valid0", ov0, vm0);
    if (vm0) begin
      chk("out_sum0", s0, q0[0].sum);
      chk("out_cout0", co0, q0[0].cout);
    end
    chk("in_ready1", r1, rdy1);
    chk("out_valid1", ov1, vm1);
    if (vm1) begin
      chk("out_sum1", s1, q1[0].sum);
      chk("out_cout1", co1, q1[0].cout);
    end
  endtask

  task automatic send0(input logic [W0-1:0] a, input logic [W0-1:0] b, input logic cin);
    int n = 0;
    a0 = a; b0 = b; c0 = cin; v0 = 1'b1;
    do begin tick(); n++; end while (!acc0_f && n < 20);
    v0 = 1'b0;
    t_acc0 = cyc;
    chk("accepted0", acc0_f, 1);
  endtask

  task automatic wait0(input logic [W0-1:0] es, input logic ec, input int elat);
    int n = 0;
    while (ov0 !== 1'b1 && n < 40) begin tick(); n++; end
    chk("latency0", cyc - t_acc0, elat);
    chk("sum0", s0, es);
    chk("cout0", co0, ec);
  endtask

  task automatic send1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin);
    int n = 0;
    a1 = a; b1 = b; c1 = cin; v1 = 1'b1;
    do begin tick(); n++; end while (!acc1_f && n < 20);
    v1 = 1'b0;
    t_acc1 = cyc;
    chk("accepted1", acc1_f, 1);
  endtask

  task automatic wait1(input logic [W1-1:0] es, input logic ec, input int elat);
    int n = 0;
    while (ov1 !== 1'b1 && n < 40) begin tick(); n++; end
    chk("latency1", cyc - t_acc1, elat);
    chk("sum1", s1, es);
    chk("cout1", co1, ec);
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; or0 = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b1;
    repeat (2) tick();
    chk("rst_valid", ov0, 0);
    chk("rst_sum", s0, 0);
    chk("rst_cout", co0, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", r0, 1);

    // carry across two segment boundaries, then a full-width ripple
    send0(16'h00FF, 16'h0001, 1'b0); wait0(16'h0100, 1'b0, LAT_T1);
    send0(16'hFFFF, 16'h0000, 1'b1); wait0(16'h0000, 1'b1, 4);

    // padded last segment on the 10-bit instance
    send1(10'h3FF, 10'h001, 1'b0); wait1(10'h000, 1'b1, 3);
    send1(10'h155, 10'h0AA, 1'b0); wait1(10'h1FF, 1'b0, 3);

    // consumer stall with a pending producer, then same-edge release and accept
    or0 = 1'b0;
    send0(16'h1234, 16'h0101, 1'b0); wait0(16'h1335, 1'b0, 4);
    a0 = 16'h0F0F; b0 = 16'h00F1; c0 = 1'b0; v0 = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_ready", r0, 0);
      chk("hold_valid", ov0, 1);
      chk("hold_sum", s0, 16'h1335);
    end
    or0 = 1'b1;
    tick();
    chk("b2b_accept", acc0_f, 1);
    chk("b2b_valid_drop", ov0, 0);
    v0 = 1'b0;
    t_acc0 = cyc;
    wait0(16'h1000, 1'b0, 4);

    // reset while segment 2 is being added
    send0(16'h5555, 16'h1111, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", ov0, 0);
    chk("midrst_ready", r0, 1);
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", ov0, 0);
    send0(16'h1234, 16'h1111, 1'b0); wait0(16'h2345, 1'b0, 4);

    // small operands: early finish when enabled
    send0(16'h0003, 16'h0004, 1'b0); wait0(16'h0007, 1'b0, LAT_T6);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpa_segmented_seq.md
Name: cpa_segmented_seq

Overview:
- Final carry-propagate stage of the modular-square datapath, downstream of the compressor tree.
- Consumes the two residual rows left after the last 3:2 reduction level: sum vector A and carry vector B, already column-aligned and flattened to WIDTH bits.
- Adds them over multiple cycles, SEG_WIDTH bits per cycle, so the long ripple chain is split across clocks.
- Uses valid/ready on both input and output.

Parameters:
- WIDTH, 2092, operand width in bits (NUM_COLS+1 of the upstream array).
- SEG_WIDTH, 128, bits added per cycle; NUM_SEGS = ceil(WIDTH/SEG_WIDTH), derived.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  sum row.
- in_b  input  WIDTH  carry row.
- in_cin  input  1  carry-in added at bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  (A+B+cin) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low. All state updates on the rising edge of clk; rst_n is sampled only there.
- Reset (rst_n=0 at an edge): state=IDLE, seg_cnt=0, carry reg=0, out_valid=0, out_sum=0, out_cout=0. in_ready reads 1 from the first cycle after reset.
- Reset mid-operation: the in-flight transaction is discarded and no out_valid is produced for it.
- FSM states IDLE, ADD, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; no dependence on in_valid.
  - Accept (in_valid && in_ready at an edge): latch in_a, in_b, in_cin; carry reg<=in_cin; seg_cnt<=0; go to ADD.
  - ADD, each edge: operate on segment k=seg_cnt, bits [k*SEG_WIDTH +: SEG_WIDTH], using zero-padded bits above WIDTH-1.
    - {c, s} = a_seg + b_seg + carry.
    - s is written into out_sum segment k; carry<=c.
    - On k==NUM_SEGS-1: out_cout<=carry out of bit WIDTH-1 (in the padded case, bit WIDTH of that segment sum, not c); go to DONE with out_valid<=1. Otherwise seg_cnt<=k+1.
  - DONE: out_valid=1 and out_sum/out_cout are stable until out_valid && out_ready.
    - On that handshake with no simultaneous accept: out_valid<=0, go to IDLE.
    - With a simultaneous accept: out_valid<=0, go to ADD with the new operands. Back-to-back throughput is one result per NUM_SEGS+1 cycles.
- Latency: result visible (out_valid=1) NUM_SEGS cycles after the accepting edge.
- out_sum bits are only guaranteed while out_valid=1. During ADD, already-written segments may be visible.
- in_valid while busy (ADD, or DONE without out_ready): ignored, in_ready=0. The upstream stage must hold its data.
- out_ready while out_valid=0: no effect.
- Arithmetic is unsigned; no overflow flag beyond out_cout.

Optional Feature:
- Macro: CPA_EARLY_TERMINATE_EN.
- Defined: at each ADD edge, if the carry produced by segment k is 0 and all latched a/b bits above segment k are zero, the block finishes immediately.
  - Writes zeros to all higher out_sum segments, sets out_cout=0 and goes to DONE.
  - Latency becomes (index of highest nonzero segment, or segment 0 if none)+1 cycles.
- Not defined: fixed NUM_SEGS-cycle latency, no zero-detect logic synthesized.

Test Plan:
1. WIDTH=16, SEG_WIDTH=4; a=0x00FF, b=0x0001, cin=0, out_ready=1 -> out_sum=0x0100, out_cout=0, out_valid rises exactly 4 cycles after accept.
2. a=0xFFFF, b=0x0000, cin=1 -> full carry ripple across all segments: out_sum=0x0000, out_cout=1.
3. WIDTH=10, SEG_WIDTH=4 (padded last segment); a=0x3FF, b=0x001 -> out_sum=0x000, out_cout=1, latency 3.
4. Hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> out_sum held, in_ready=0; raise out_ready -> same-edge accept, next result correct after 4 more cycles.
5. Assert rst_n=0 during ADD seg 2 -> next cycle out_valid=0, in_ready=1; a fresh transaction a=0x1234, b=0x1111 -> 0x2345.
6. With CPA_EARLY_TERMINATE_EN: a=0x0003, b=0x0004 -> out_sum=0x0007, out_valid 1 cycle after accept. Without the macro: 4 cycles after accept.
